// File: rtl/key_event_pkg.sv
// Shared types and defaults for the key event decoder and its tick prescaler.
package key_event_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDown1  = 3'd1,
    StLong   = 3'd2,
    StUpWait = 3'd3,
    StDown2  = 3'd4
  } key_state_e;

  localparam int unsigned TickDivDefault   = 100000;
  localparam int unsigned LongTicksDefault = 1000;
  localparam int unsigned DclkTicksDefault = 250;
  localparam int unsigned CntWDefault      = 11;

  function automatic logic is_pressed(key_state_e s);
    return (s == StDown1) || (s == StLong) || (s == StDown2);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one cycle every TICK_DIV clocks.
module tick_prescaler
  import key_event_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CntLast);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies a debounced button level into press/release/click/double-click/long pulses.
// Double-click detection (UP_WAIT/DOWN2) is built only when KEY_DCLICK_EN is defined.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TickDivDefault,
  parameter int unsigned LONG_TICKS = LongTicksDefault,
  parameter int unsigned DCLK_TICKS = DclkTicksDefault,
  parameter int unsigned CNT_W      = CntWDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic db,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dclick_p,
  output logic long_p,
  output logic held
);

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);

  key_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_ev_cnt;
  logic             r_db_q;
  logic             r_press, r_release, r_click, r_long, r_held;
  logic             w_press, w_release, w_click, w_long;
  logic             w_rise, w_fall, w_tick, w_long_to;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign w_rise    = db & ~r_db_q;
  assign w_fall    = ~db & r_db_q;
  assign w_long_to = w_tick && (r_ev_cnt == LongLast);

`ifdef KEY_DCLICK_EN
  localparam logic [CNT_W-1:0] DclkLast = CNT_W'(DCLK_TICKS - 1);
  logic w_dclk_to, w_dclick, r_dclick;
  assign w_dclk_to = w_tick && (r_ev_cnt == DclkLast);
`endif

  // Edges are tested before timeouts so an edge wins a same-cycle collision.
  always_comb begin
    w_state_d = r_state;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_click   = 1'b0;
    w_long    = 1'b0;
`ifdef KEY_DCLICK_EN
    w_dclick  = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_d = StDown1;
          w_press   = 1'b1;
        end
      end
      StDown1: begin
        if (w_fall) begin
          w_release = 1'b1;
`ifdef KEY_DCLICK_EN
          w_state_d = StUpWait;
`else
          w_state_d = StIdle;
          w_click   = 1'b1;
`endif
        end else if (w_long_to) begin
          w_state_d = StLong;
          w_long    = 1'b1;
        end
      end
      StLong: begin
        if (w_fall) begin
          w_state_d = StIdle;
          w_release = 1'b1;
        end
      end
`ifdef KEY_DCLICK_EN
      StUpWait: begin
        if (w_rise) begin
          w_state_d = StDown2;
          w_press   = 1'b1;
        end else if (w_dclk_to) begin
          w_state_d = StIdle;
          w_click   = 1'b1;
        end
      end
      StDown2: begin
        if (w_fall) begin
          w_state_d = StIdle;
          w_release = 1'b1;
          w_dclick  = 1'b1;
        end else if (w_long_to) begin
          w_state_d = StLong;
          w_long    = 1'b1;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_ev_cnt  <= '0;
      r_db_q    <= db;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_db_q    <= db;
      r_press   <= w_press;
      r_release <= w_release;
      r_click   <= w_click;
      r_long    <= w_long;
      r_held    <= is_pressed(w_state_d);
      if (w_state_d != r_state) begin
        r_ev_cnt <= '0;
      end else if (w_tick && (r_ev_cnt != '1)) begin
        r_ev_cnt <= r_ev_cnt + 1'b1;
      end
    end
  end

`ifdef KEY_DCLICK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dclick <= 1'b0;
    end else begin
      r_dclick <= w_dclick;
    end
  end
  assign dclick_p = r_dclick;
`else
  assign dclick_p = 1'b0;
`endif

  assign press_p   = r_press;
  assign release_p = r_release;
  assign click_p   = r_click;
  assign long_p    = r_long;
  assign held      = r_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scripted gestures plus random button activity checked cycle by cycle against a gesture model.
module tb_key_event_decoder;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned LongTicks = 8;
  localparam int unsigned DclkTicks = 3;
  localparam int unsigned CntW      = 11;
`ifdef KEY_DCLICK_EN
  localparam bit DclkEn = 1'b1;
`else
  localparam bit DclkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic db  = 1'b0;
  logic press_p, release_p, click_p, dclick_p, long_p, held;

  key_event_decoder #(
    .TICK_DIV  (TickDiv),
    .LONG_TICKS(LongTicks),
    .DCLK_TICKS(DclkTicks),
    .CNT_W     (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .db       (db),
    .press_p  (press_p),
    .release_p(release_p),
    .click_p  (click_p),
    .dclick_p (dclick_p),
    .long_p   (long_p),
    .held     (held)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gesture model: tracks whether the button is down, whether a hold became long,
  // how many presses the current gesture has, and whether a second press is awaited.
  int   m_phase, m_ticks, m_presses;
  bit   m_down, m_long, m_gap, m_prev;
  logic [5:0] exp_v;

  task automatic model_step(input logic d, input logic r);
    bit tick, rise, fall, chg;
    bit p, rl, c, dc, lg;
    p = 0; rl = 0; c = 0; dc = 0; lg = 0; chg = 0;
    if (!r) begin
      m_phase = 0; m_ticks = 0; m_presses = 0;
      m_down = 0; m_long = 0; m_gap = 0; m_prev = d;
      exp_v = '0;
    end else begin
      tick = (m_phase == TickDiv - 1);
      rise = d && !m_prev;
      fall = !d && m_prev;
      if (m_gap) begin
        if (rise) begin
          p = 1; m_gap = 0; m_down = 1; m_presses = 2; chg = 1;
        end else if (tick && m_ticks == DclkTicks - 1) begin
          c = 1; m_gap = 0; m_presses = 0; chg = 1;
        end
      end else if (!m_down) begin
        if (rise) begin
          p = 1; m_down = 1; m_presses = 1; m_long = 0; chg = 1;
        end
      end else if (m_long) begin
        if (fall) begin
          rl = 1; m_down = 0; m_long = 0; m_presses = 0; chg = 1;
        end
      end else begin
        if (fall) begin
          rl = 1; m_down = 0; chg = 1;
          if (m_presses == 2) begin
            dc = 1; m_presses = 0;
          end else if (DclkEn) begin
            m_gap = 1;
          end else begin
            c = 1; m_presses = 0;
          end
        end else if (tick && m_ticks == LongTicks - 1) begin
          lg = 1; m_long = 1; chg = 1;
        end
      end
      if (chg) m_ticks = 0;
      else if (tick && m_ticks < (1 << CntW) - 1) m_ticks++;
      m_phase = (m_phase + 1) % TickDiv;
      m_prev  = d;
      exp_v   = {p, rl, c, dc, lg, m_down};
    end
  endtask

  int n_press, n_rel, n_click, n_dclick, n_long, n_relclick, n_reldclick;

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0;
    n_long = 0; n_relclick = 0; n_reldclick = 0;
  endtask

  task automatic cycle(input logic d, input logic r);
    @(negedge clk);
    db  = d;
    rst = r;
    @(posedge clk);
    model_step(d, r);
    #1;
    check_eq("outputs", {26'd0, press_p, release_p, click_p, dclick_p, long_p, held},
             {26'd0, exp_v});
    n_press     += int'(press_p);
    n_rel       += int'(release_p);
    n_click     += int'(click_p);
    n_dclick    += int'(dclick_p);
    n_long      += int'(long_p);
    n_relclick  += int'(release_p & click_p);
    n_reldclick += int'(release_p & dclick_p);
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) cycle(d, 1'b1);
  endtask

  initial begin
    bit found;
    logic lvl;

    // Button held through reset must not produce a press.
    clear_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    hold(1'b1, 50);
    check_eq("reset_no_press", n_press, 0);
    check_eq("reset_quiet", n_rel + n_click + n_dclick + n_long, 0);
    hold(1'b0, 20);

    // Single click.
    clear_counts();
    hold(1'b1, 10);
    hold(1'b0, 20);
    check_eq("click_press", n_press, 1);
    check_eq("click_release", n_rel, 1);
    check_eq("click_click", n_click, 1);
    check_eq("click_dclick", n_dclick, 0);
    check_eq("click_samecycle", n_relclick, DclkEn ? 0 : 1);

    // Double click.
    clear_counts();
    hold(1'b1, 6);
    hold(1'b0, 5);
    hold(1'b1, 6);
    hold(1'b0, 20);
    check_eq("dclk_press", n_press, 2);
    check_eq("dclk_dclick", n_dclick, DclkEn ? 1 : 0);
    check_eq("dclk_with_release", n_reldclick, DclkEn ? 1 : 0);
    check_eq("dclk_click", n_click, DclkEn ? 0 : 2);

    // Long press.
    clear_counts();
    hold(1'b1, 40);
    check_eq("long_once", n_long, 1);
    hold(1'b0, 20);
    check_eq("long_release", n_rel, 1);
    check_eq("long_noclick", n_click + n_dclick, 0);

    // Second press lands on the cycle the double-click window expires.
    if (DclkEn) begin
      clear_counts();
      hold(1'b1, 6);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        if (m_gap && m_phase == TickDiv - 1 && m_ticks == DclkTicks - 1) begin
          found = 1;
          cycle(1'b1, 1'b1);
        end else begin
          cycle(1'b0, 1'b1);
        end
      end
      check_eq("collide_found", found, 1);
      check_eq("collide_press", n_press, 2);
      check_eq("collide_noclick", n_click, 0);
      hold(1'b1, 5);
      hold(1'b0, 20);
      check_eq("collide_dclick", n_dclick, 1);
    end

    // Random activity with occasional mid-gesture resets.
    lvl = 1'b0;
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) cycle(1'($urandom), 1'b0);
      end
      lvl = ~lvl;
      hold(lvl, int'($urandom_range(1, 45)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
